// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt sequencer feeding the 7-phase clock controller.
// Commands from the debug/host side and HLT from decode are applied only on
// instruction boundaries (retire = alive while the last phase is active).
// All outputs are registered; they are derived from the next state so they
// change in the same cycle as the state register.
module cpu_run_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic             halt_req,
  input  logic             count_clr,
  input  logic [6:0]       clk_sequence,
  output logic             alive,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             stop_pending_r;
  logic             stop_pending_s;
  logic             retire_s;
  logic [CNT_W-1:0] count_s;
  logic             seq_unused_s;

  // Only the last phase matters here; the earlier phases are observed but unused.
  assign seq_unused_s = ^clk_sequence[5:0];

  // An instruction retires when the phase generator is enabled in its last phase.
  assign retire_s = alive & clk_sequence[6];

  // Next-state logic: boundary decisions use halt > start-upgrade > stop priority.
  always_comb begin
    state_s        = state_r;
    stop_pending_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_s = ST_RUN;
        end else if (step) begin
          state_s = ST_STEP;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (retire_s) begin
          if (halt_req) begin
            state_s = ST_HALTED;
          end else if (stop | stop_pending_r) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          // A stop mid-instruction is remembered until the next boundary.
          state_s        = ST_RUN;
          stop_pending_s = stop_pending_r | stop;
        end
      end
      ST_STEP: begin
        if (retire_s) begin
          if (halt_req) begin
            state_s = ST_HALTED;
          end else if (start) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_STEP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Retired-instruction counter: clear beats increment; wraps naturally.
  always_comb begin
    count_s = instr_count;
    if (count_clr) begin
      count_s = '0;
    end else if (retire_s) begin
      count_s = instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_s = instr_count;
    end
  end

  // State, pending-stop flag, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      stop_pending_r <= 1'b0;
      alive          <= 1'b0;
      running        <= 1'b0;
      halted         <= 1'b0;
      instr_count    <= '0;
    end else begin
      state_r        <= state_s;
      stop_pending_r <= stop_pending_s;
      alive          <= (state_s == ST_RUN) | (state_s == ST_STEP);
      running        <= (state_s == ST_RUN);
      halted         <= (state_s == ST_HALTED);
      instr_count    <= count_s;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: a behavioural clock-controller model
// produces clk_sequence, and a mode-level reference model predicts outputs.
module tb_cpu_run_controller;

  logic        clk;
  logic        rst_n;
  logic        start, step, stop, halt_req, count_clr;
  logic [6:0]  seq;
  logic        alive32, running32, halted32;
  logic [31:0] count32;
  logic        alive4, running4, halted4;
  logic [3:0]  count4;

  int errs   = 0;
  int checks = 0;

  cpu_run_controller #(.CNT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .halt_req(halt_req), .count_clr(count_clr), .clk_sequence(seq),
    .alive(alive32), .running(running32), .halted(halted32), .instr_count(count32)
  );

  cpu_run_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .halt_req(halt_req), .count_clr(count_clr), .clk_sequence(seq),
    .alive(alive4), .running(running4), .halted(halted4), .instr_count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_HALT} mmode_t;
  mmode_t      m_mode;
  bit          m_pend;
  bit          m_rest;
  logic [31:0] m_count;
  wire         m_alive    = (m_mode == M_RUN) || (m_mode == M_STEP);
  wire         m_boundary = m_alive && seq[6];

  // Clock controller, instruction mode and retire count, one step per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= M_IDLE;
      m_pend  <= 1'b0;
      m_rest  <= 1'b1;
      m_count <= 32'd0;
      seq     <= 7'b0000001;
    end else begin
      // clock controller: from rest phase 0 lasts two cycles, then 1..6, wrap
      if (!m_alive) begin
        seq    <= 7'b0000001;
        m_rest <= 1'b1;
      end else if (m_rest) begin
        m_rest <= 1'b0;
      end else begin
        seq <= {seq[5:0], seq[6]};
      end
      if (count_clr) m_count <= 32'd0;
      else if (m_boundary) m_count <= m_count + 32'd1;
      case (m_mode)
        M_IDLE, M_HALT: begin
          if (start) m_mode <= M_RUN;
          else if (step) m_mode <= M_STEP;
        end
        M_RUN: begin
          if (m_boundary)
            m_mode <= halt_req ? M_HALT : ((stop || m_pend) ? M_IDLE : M_RUN);
        end
        M_STEP: begin
          if (m_boundary) m_mode <= halt_req ? M_HALT : (start ? M_RUN : M_IDLE);
          else if (start) m_mode <= M_RUN;
        end
        default: m_mode <= M_IDLE;
      endcase
      m_pend <= (m_mode == M_RUN && !m_boundary) ? (m_pend || stop) : 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
  endtask

  task automatic stop_and_wait();
    stop = 1'b1; tick(1); stop = 1'b0;
    for (int i = 0; i < 40 && alive32; i++) tick(1);
    checks++;
    if (alive32 !== 1'b0) begin errs++; $display("FAIL stop_wait alive=%b want 0", alive32); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if ({alive32, running32, halted32} !== 3'b000 || count32 !== 32'd0) begin
        errs++;
        $display("FAIL reset_idle a/r/h=%b%b%b cnt=%0d want 000/0", alive32, running32, halted32, count32);
      end
    end
    // reset in the middle of a running instruction
    start = 1'b1; tick(1); start = 1'b0;
    tick(12);
    checks++;
    if (running32 !== 1'b1) begin errs++; $display("FAIL reset_prerun running=%b want 1", running32); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (alive32 !== 1'b0 || count32 !== 32'd0 || running32 !== 1'b0) begin
      errs++;
      $display("FAIL reset_async alive=%b running=%b cnt=%0d want 0/0/0", alive32, running32, count32);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_step();
    int n;
    n = 0;
    step = 1'b1; tick(1); step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (alive32) n++;
      tick(1);
    end
    checks++;
    if (n != 8) begin errs++; $display("FAIL step_alive_cycles got=%0d want 8", n); end
    checks++;
    if (count32 !== 32'd1 || running32 !== 1'b0 || halted32 !== 1'b0) begin
      errs++;
      $display("FAIL step_end cnt=%0d running=%b halted=%b want 1/0/0", count32, running32, halted32);
    end
  endtask

  task automatic test_stop();
    pulse_clr();
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 200 && !(count32 == 32'd4 && seq[3]); i++) tick(1);
    checks++;
    if (!(count32 == 32'd4 && seq[3])) begin errs++; $display("FAIL stop_p3_wait cnt=%0d seq=%b", count32, seq); end
    stop = 1'b1; tick(1); stop = 1'b0;
    for (int i = 0; i < 40 && alive32; i++) tick(1);
    checks++;
    if (alive32 !== 1'b0 || count32 !== 32'd5 || running32 !== 1'b0) begin
      errs++;
      $display("FAIL stop_p3 alive=%b cnt=%0d running=%b want 0/5/0", alive32, count32, running32);
    end
    // stop coincident with the retire of instruction 2
    pulse_clr();
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 100 && !(count32 == 32'd1 && seq[6]); i++) tick(1);
    stop = 1'b1; tick(1); stop = 1'b0;
    checks++;
    if (alive32 !== 1'b0 || count32 !== 32'd2) begin
      errs++;
      $display("FAIL stop_at_retire alive=%b cnt=%0d want 0/2", alive32, count32);
    end
    // stop one cycle after the retire of instruction 1 acts at the next boundary
    pulse_clr();
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 100 && count32 != 32'd1; i++) tick(1);
    stop = 1'b1; tick(1); stop = 1'b0;
    checks++;
    if (alive32 !== 1'b1) begin errs++; $display("FAIL stop_late_alive alive=%b want 1", alive32); end
    for (int i = 0; i < 40 && alive32; i++) tick(1);
    checks++;
    if (alive32 !== 1'b0 || count32 !== 32'd2) begin
      errs++;
      $display("FAIL stop_late alive=%b cnt=%0d want 0/2", alive32, count32);
    end
  endtask

  task automatic test_halt();
    pulse_clr();
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 200 && !(count32 == 32'd2 && seq[6]); i++) tick(1);
    halt_req = 1'b1; tick(1); halt_req = 1'b0;
    checks++;
    if (halted32 !== 1'b1 || alive32 !== 1'b0 || count32 !== 32'd3) begin
      errs++;
      $display("FAIL halt halted=%b alive=%b cnt=%0d want 1/0/3", halted32, alive32, count32);
    end
    stop = 1'b1; tick(1); stop = 1'b0; tick(3);
    checks++;
    if (halted32 !== 1'b1 || alive32 !== 1'b0 || count32 !== 32'd3) begin
      errs++;
      $display("FAIL halt_stop halted=%b alive=%b cnt=%0d want 1/0/3", halted32, alive32, count32);
    end
    start = 1'b1; tick(1); start = 1'b0;
    checks++;
    if (halted32 !== 1'b0 || running32 !== 1'b1) begin
      errs++;
      $display("FAIL halt_restart halted=%b running=%b want 0/1", halted32, running32);
    end
    stop_and_wait();
  endtask

  task automatic test_start_step();
    start = 1'b1; step = 1'b1; tick(1); start = 1'b0; step = 1'b0;
    checks++;
    if (running32 !== 1'b1 || alive32 !== 1'b1) begin
      errs++;
      $display("FAIL start_step running=%b alive=%b want 1/1", running32, alive32);
    end
    stop_and_wait();
    pulse_clr();
    step = 1'b1; tick(1); step = 1'b0;
    for (int i = 0; i < 20 && !seq[4]; i++) tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 20 && count32 != 32'd1; i++) tick(1);
    tick(3);
    checks++;
    if (running32 !== 1'b1 || alive32 !== 1'b1 || count32 !== 32'd1) begin
      errs++;
      $display("FAIL step_upgrade running=%b alive=%b cnt=%0d want 1/1/1", running32, alive32, count32);
    end
    stop_and_wait();
    checks++;
    if (count32 !== 32'd2) begin errs++; $display("FAIL step_upgrade_stop cnt=%0d want 2", count32); end
  endtask

  task automatic test_wrap_clr();
    pulse_clr();
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 300 && count32 != 32'd16; i++) tick(1);
    checks++;
    if (count4 !== 4'd0 || count32 !== 32'd16) begin
      errs++;
      $display("FAIL wrap cnt4=%0d cnt32=%0d want 0/16", count4, count32);
    end
    for (int i = 0; i < 20 && !seq[6]; i++) tick(1);
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
    checks++;
    if (count4 !== 4'd0 || count32 !== 32'd0 || m_count !== 32'd0) begin
      errs++;
      $display("FAIL clr_at_retire cnt4=%0d cnt32=%0d want 0/0", count4, count32);
    end
    stop_and_wait();
    checks++;
    if (count4 !== 4'd1 || count32 !== 32'd1) begin
      errs++;
      $display("FAIL clr_then_stop cnt4=%0d cnt32=%0d want 1/1", count4, count32);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(23) == 0);
      step      = ($urandom_range(15) == 0);
      stop      = ($urandom_range(9) == 0);
      halt_req  = ($urandom_range(7) == 0);
      count_clr = ($urandom_range(59) == 0);
      tick(1);
      checks++;
      if (alive32 !== m_alive || running32 !== (m_mode == M_RUN) || halted32 !== (m_mode == M_HALT) ||
          count32 !== m_count || count4 !== m_count[3:0] || alive4 !== m_alive ||
          running4 !== (m_mode == M_RUN) || halted4 !== (m_mode == M_HALT)) begin
        errs++;
        $display("FAIL random cyc=%0d a/r/h=%b%b%b cnt=%0d cnt4=%0d want %b%b%b cnt=%0d",
                 i, alive32, running32, halted32, count32, count4,
                 m_alive, (m_mode == M_RUN), (m_mode == M_HALT), m_count);
      end
    end
    start = 1'b0; step = 1'b0; stop = 1'b0; halt_req = 1'b0; count_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; halt_req = 1'b0; count_clr = 1'b0;
    tick(1);
    test_reset();
    test_step();
    test_stop();
    test_halt();
    test_start_step();
    test_wrap_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
